md_unit: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit with HI/LO registers, fed from the E stage.

---
 rtl/md_pkg.sv | 38 +++
 rtl/md_unit_if.sv | 18 +
 rtl/md_divider.sv | 40 ++++
 rtl/md_unit.sv | 120 ++++++++++++
 tb/tb_md_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// MD_UNIT_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package md_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MTHI  = 4'd4,
        MTLO  = 4'd5,
        MADD  = 4'd6,
        MADDU = 4'd7,
        MSUB  = 4'd8,
        MSUBU = 4'd9
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    // True for ops that occupy the unit for a multi-cycle busy period.
    function automatic logic md_is_long(input md_op_t op);
        case (op)
            MULT, MULTU, DIV, DIVU:   return 1'b1;
`ifdef MD_UNIT_MADD_EN
            MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div(input md_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Bundle between the E stage (master) and the multiply/divide unit (slave).
interface md_unit_if #(
    parameter int W = 32
) ();
    import md_pkg::*;

    logic         start;
    md_op_t       op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (output start, op, a, b, abort, input  busy, hi, lo);
    modport slave  (input  start, op, a, b, abort, output busy, hi, lo);
endinterface

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider: quotient truncates toward zero,
// remainder takes the dividend's sign; divide-by-zero and overflow are guarded.
module md_divider #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         div_zero
);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic         a_neg, b_neg, overflow;
    logic [W-1:0] a_mag, b_mag, q_mag, r_mag;

    // NOTE: every output of a combinational block gets a default up front so no path leaves it unassigned and infers a latch.
    always_comb begin
        a_neg    = is_signed & a[W-1];
        b_neg    = is_signed & b[W-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = (b == '0);
        overflow = is_signed && (a == MIN_NEG) && (b == '1);
        q_mag    = '0;
        r_mag    = '0;
        if (!div_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem  = a_neg ? -r_mag : r_mag;
        // -2^(W-1) / -1 is not representable; pin it explicitly.
        if (overflow) begin
            quot = MIN_NEG;
            rem  = '0;
        end
    end
endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and abort.
// Define MD_UNIT_MADD_EN to build the MADD/MSUB accumulator path.
module md_unit
    import md_pkg::*;
#(
    parameter int W       = 32,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);
    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    md_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0] hi, lo, hi_n, lo_n;
    logic [W-1:0] hi_p, lo_p, hi_p_n, lo_p_n;

    logic           mul_signed;
    logic [2*W-1:0] a_ext, b_ext, prod;
    logic [2*W-1:0] res;
    logic [W-1:0]   quot, rem;
    logic           div_zero;

    md_divider #(.W(W)) u_div (
        .a        (md.a),
        .b        (md.b),
        .is_signed(md.op == DIV),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    // One shared 2W-bit multiplier; sign- or zero-extension selects the flavour.
    always_comb begin
        mul_signed = (md.op == MULT) || (md.op == MADD) || (md.op == MSUB);
        a_ext      = mul_signed ? {{W{md.a[W-1]}}, md.a} : {{W{1'b0}}, md.a};
        b_ext      = mul_signed ? {{W{md.b[W-1]}}, md.b} : {{W{1'b0}}, md.b};
        prod       = a_ext * b_ext;
    end

    always_comb begin
        res = prod;
        case (md.op)
            DIV, DIVU:    res = div_zero ? {hi, lo} : {rem, quot};
`ifdef MD_UNIT_MADD_EN
            MADD, MADDU:  res = {hi, lo} + prod;
            MSUB, MSUBU:  res = {hi, lo} - prod;
`endif
            default:      res = prod;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi;
        lo_n    = lo;
        hi_p_n  = hi_p;
        lo_p_n  = lo_p;
        if (md.abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            hi_p_n  = '0;
            lo_p_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md.start) begin
                        if (md_is_long(md.op)) begin
                            state_n = RUN;
                            cnt_n   = md_is_div(md.op) ? CW'(DIV_CYC) : CW'(MUL_CYC);
                            {hi_p_n, lo_p_n} = res;
                        end else if (md.op == MTHI) begin
                            hi_n = md.a;
                        end else if (md.op == MTLO) begin
                            lo_n = md.a;
                        end
                    end
                end
                RUN: begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        hi_n    = hi_p;
                        lo_n    = lo_p;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the pending result registers are reset too, so no stale operand ever survives a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            hi_p  <= '0;
            lo_p  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            hi_p  <= hi_p_n;
            lo_p  <= lo_p_n;
        end
    end

    assign md.busy = (state == RUN);
    assign md.hi   = hi;
    assign md.lo   = lo;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vectors plus randomized ops
// compared against an arithmetic reference model.
module tb_md_unit;
    import md_pkg::*;

    localparam int W       = 32;
    localparam int MUL_CYC = 5;
    localparam int DIV_CYC = 10;

    logic clk = 1'b0;
    logic reset;
    int   vec = 0;
    int   err = 0;
    bit   allow_busy_start = 1'b0;
    logic [31:0] exp_hi, exp_lo;

    md_unit_if #(.W(W)) bus ();

    md_unit #(.W(W), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk  (clk),
        .reset(reset),
        .md   (bus)
    );

    always #5 clk = ~clk;

    // Stall logic upstream must never launch while busy.
    always @(posedge clk) begin
        if (!reset && !allow_busy_start && bus.start === 1'b1 && bus.busy === 1'b1) begin
            err++;
            $display("FAIL start_while_busy: start seen with busy=%b, required no overlap", bus.busy);
        end
    end

    // Reference model: architectural effect of one op on HI/LO and its busy length.
    task automatic model_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi_in, input logic [31:0] lo_in,
                            output logic [31:0] hi_o, output logic [31:0] lo_o, output int lat);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur, p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi_o = hi_in;
        lo_o = lo_in;
        lat  = 0;
        acc  = {hi_in, lo_in};
        case (op)
            MULT:  begin lat = MUL_CYC; p = 64'(sa * sb); {hi_o, lo_o} = p; end
            MULTU: begin lat = MUL_CYC; p = ua * ub;      {hi_o, lo_o} = p; end
            DIV: begin
                lat = DIV_CYC;
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    lo_o = sq[31:0]; hi_o = sr[31:0];
                end
            end
            DIVU: begin
                lat = DIV_CYC;
                if (b != 0) begin
                    uq = ua / ub; ur = ua % ub;
                    lo_o = uq[31:0]; hi_o = ur[31:0];
                end
            end
            MTHI: hi_o = a;
            MTLO: lo_o = a;
`ifdef MD_UNIT_MADD_EN
            MADD:  begin lat = MUL_CYC; p = 64'(sa * sb); {hi_o, lo_o} = acc + p; end
            MADDU: begin lat = MUL_CYC; p = ua * ub;      {hi_o, lo_o} = acc + p; end
            MSUB:  begin lat = MUL_CYC; p = 64'(sa * sb); {hi_o, lo_o} = acc - p; end
            MSUBU: begin lat = MUL_CYC; p = ua * ub;      {hi_o, lo_o} = acc - p; end
`endif
            default: ;
        endcase
    endtask

    task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; bounded so a stuck busy still ends.
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b, output int n);
        issue(op, a, b);
        wait_idle(n);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        vec++; if (bus.busy !== 1'b0)  begin err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vec++; if (bus.hi !== 32'h0)   begin err++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        vec++; if (bus.lo !== 32'h0)   begin err++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int n;
        do_op(MULT, 32'hFFFF_FFFE, 32'd3, n);
        vec++; if (n !== MUL_CYC)         begin err++; $display("FAIL mult_lat: got %0d want %0d", n, MUL_CYC); end
        vec++; if (bus.hi !== 32'hFFFF_FFFF) begin err++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
        vec++; if (bus.lo !== 32'hFFFF_FFFA) begin err++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo); end
    endtask

    task automatic test_div;
        int n;
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, n);
        vec++; if (n !== DIV_CYC)            begin err++; $display("FAIL div_lat: got %0d want %0d", n, DIV_CYC); end
        vec++; if (bus.lo !== 32'hFFFF_FFFD) begin err++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
        vec++; if (bus.hi !== 32'hFFFF_FFFF) begin err++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end
        do_op(DIVU, 32'hFFFF_FFF9, 32'd2, n);
        vec++; if (bus.lo !== 32'h7FFF_FFFC) begin err++; $display("FAIL divu_lo: got %h want 7ffffffc", bus.lo); end
        vec++; if (bus.hi !== 32'h0000_0001) begin err++; $display("FAIL divu_hi: got %h want 00000001", bus.hi); end
    endtask

    task automatic test_mthi_div0;
        int n;
        issue(MTHI, 32'h1234_5678, 32'd0);
        vec++; if (bus.busy !== 1'b0)        begin err++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
        vec++; if (bus.hi !== 32'h1234_5678) begin err++; $display("FAIL mthi_hi: got %h want 12345678", bus.hi); end
        do_op(DIVU, 32'd5, 32'd0, n);
        vec++; if (n !== DIV_CYC)            begin err++; $display("FAIL div0_lat: got %0d want %0d", n, DIV_CYC); end
        vec++; if (bus.hi !== 32'h1234_5678) begin err++; $display("FAIL div0_hi: got %h want 12345678", bus.hi); end
        vec++; if (bus.lo !== 32'h7FFF_FFFC) begin err++; $display("FAIL div0_lo: got %h want 7ffffffc", bus.lo); end
    endtask

    task automatic test_abort_reset;
        issue(MULT, 32'h0001_0000, 32'h0001_0000);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        vec++; if (bus.busy !== 1'b0)        begin err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        repeat (MUL_CYC) @(negedge clk);
        vec++; if (bus.hi !== 32'h1234_5678) begin err++; $display("FAIL abort_hi: got %h want 12345678", bus.hi); end
        vec++; if (bus.lo !== 32'h7FFF_FFFC) begin err++; $display("FAIL abort_lo: got %h want 7ffffffc", bus.lo); end
        issue(DIV, 32'd100, 32'd7);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        vec++; if (bus.hi !== 32'h0)  begin err++; $display("FAIL rst_mid_hi: got %h want 0", bus.hi); end
        vec++; if (bus.lo !== 32'h0)  begin err++; $display("FAIL rst_mid_lo: got %h want 0", bus.lo); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_overflow_busy_start;
        int n;
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        allow_busy_start = 1'b1;
        bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd3; bus.b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        allow_busy_start = 1'b0;
        wait_idle(n);
        vec++; if (n + 1 !== DIV_CYC)        begin err++; $display("FAIL ovf_lat: got %0d want %0d", n + 1, DIV_CYC); end
        vec++; if (bus.lo !== 32'h8000_0000) begin err++; $display("FAIL ovf_lo: got %h want 80000000", bus.lo); end
        vec++; if (bus.hi !== 32'h0)         begin err++; $display("FAIL ovf_hi: got %h want 0", bus.hi); end
        @(negedge clk);
        vec++; if (bus.busy !== 1'b0)        begin err++; $display("FAIL no_queue_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_madd;
        int n;
        issue(MTHI, 32'h0, 32'h0);
        issue(MTLO, 32'hFFFF_FFFF, 32'h0);
        do_op(MADDU, 32'd1, 32'd1, n);
`ifdef MD_UNIT_MADD_EN
        vec++; if (n !== MUL_CYC)     begin err++; $display("FAIL madd_lat: got %0d want %0d", n, MUL_CYC); end
        vec++; if (bus.hi !== 32'h1)  begin err++; $display("FAIL madd_hi: got %h want 1", bus.hi); end
        vec++; if (bus.lo !== 32'h0)  begin err++; $display("FAIL madd_lo: got %h want 0", bus.lo); end
`else
        vec++; if (n !== 0)                  begin err++; $display("FAIL madd_off_lat: got %0d want 0", n); end
        vec++; if (bus.hi !== 32'h0)         begin err++; $display("FAIL madd_off_hi: got %h want 0", bus.hi); end
        vec++; if (bus.lo !== 32'hFFFF_FFFF) begin err++; $display("FAIL madd_off_lo: got %h want ffffffff", bus.lo); end
`endif
    endtask

    task automatic test_random;
        int          n, lat, r, sel;
        md_op_t      op;
        logic [31:0] a, b, nh, nl;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        for (int i = 0; i < 80; i++) begin
            r   = int'($urandom_range(0, 15));
            op  = md_op_t'(r[3:0]);
            a   = $urandom;
            b   = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'(int'($urandom_range(1, 9)));
            model_op(op, a, b, exp_hi, exp_lo, nh, nl, lat);
            do_op(op, a, b, n);
            exp_hi = nh;
            exp_lo = nl;
            vec++; if (n !== lat)       begin err++; $display("FAIL rnd_lat[%0d] op=%0d: got %0d want %0d", i, r, n, lat); end
            vec++; if (bus.hi !== exp_hi) begin err++; $display("FAIL rnd_hi[%0d] op=%0d a=%h b=%h: got %h want %h", i, r, a, b, bus.hi, exp_hi); end
            vec++; if (bus.lo !== exp_lo) begin err++; $display("FAIL rnd_lo[%0d] op=%0d a=%h b=%h: got %h want %h", i, r, a, b, bus.lo, exp_lo); end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.abort = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_div0();
        test_abort_reset();
        test_overflow_busy_start();
        test_madd();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
